// File: rtl/mips_multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, functs, ALU ops,
// controller states and small datapath helpers.
package mips_multicycle_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_IMMEX,
        S_IMMWB,
        S_JUMP,
        S_TRAP
    } state_t;

    function automatic u32 alu(input alu_op_t op, input u32 a, input u32 b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'b0, ($signed(a) < $signed(b))};
            default: return a + b;
        endcase
    endfunction

    function automatic u32 sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_multicycle_regfile.sv
// 32 x 32 register file: two asynchronous read ports, one synchronous write port,
// register 0 hardwired to zero.
module mips_multicycle_regfile
    import mips_multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic [4:0] ra1,
    input  logic [4:0] ra2,
    input  logic       we,
    input  logic [4:0] wa,
    input  u32         wd,
    output u32         rd1,
    output u32         rd2
);

    u32 regs [32];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (srst || gi == 0) begin
                    regs[gi] <= '0;
                end else if (we && wa == 5'(gi)) begin
                    regs[gi] <= wd;
                end
            end
        end
    endgenerate

    // A write in the same cycle as a read returns the old contents.
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core with a single shared req/ready memory port, retire pulse
// and sticky illegal-instruction trap.
module mips_multicycle
    import mips_multicycle_pkg::*;
#(
    parameter u32 RESET_PC = 32'h0000_0000,
    parameter int EXT_OPS  = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        instr_done,
    output logic        illegal
);

    state_t state_reg;
    u32     ir_reg;
    u32     a_reg;
    u32     b_reg;
    u32     aluout_reg;
    u32     mdr_reg;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    u32          imm_sext;
    u32          imm_zext;

    assign opcode   = ir_reg[31:26];
    assign rs       = ir_reg[25:21];
    assign rt       = ir_reg[20:16];
    assign rd       = ir_reg[15:11];
    assign funct    = ir_reg[5:0];
    assign imm      = ir_reg[15:0];
    assign imm_sext = sext16(imm);
    assign imm_zext = {16'b0, imm};

    u32         rf_rd1;
    u32         rf_rd2;
    u1          rf_we;
    logic [4:0] rf_wa;
    u32         rf_wd;

    mips_multicycle_regfile u_regfile (
        .clk  (clk),
        .srst (reset),
        .ra1  (rs),
        .ra2  (rt),
        .we   (rf_we),
        .wa   (rf_wa),
        .wd   (rf_wd),
        .rd1  (rf_rd1),
        .rd2  (rf_rd2)
    );

    state_t  decode_state;
    alu_op_t alu_op;
    u1       funct_ok;
    u32      imm_result;
    u1       branch_taken;
    u1       retire;
    u32      next_pc;

    always_comb begin
        decode_state = S_TRAP;
        case (opcode)
            OP_RTYPE:      decode_state = S_EXEC;
            OP_LW, OP_SW:  decode_state = S_MEMADR;
            OP_BEQ:        decode_state = S_BRANCH;
            OP_BNE:        decode_state = (EXT_OPS != 0) ? S_BRANCH : S_TRAP;
            OP_ADDI:       decode_state = S_IMMEX;
            OP_ANDI,
            OP_ORI:        decode_state = (EXT_OPS != 0) ? S_IMMEX : S_TRAP;
            OP_J:          decode_state = S_JUMP;
            default:       decode_state = S_TRAP;
        endcase
    end

    always_comb begin
        alu_op   = ALU_ADD;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_ANDI: imm_result = a_reg & imm_zext;
            OP_ORI:  imm_result = a_reg | imm_zext;
            default: imm_result = a_reg + imm_sext;
        endcase
    end

    assign branch_taken = (opcode == OP_BNE) ? (a_reg != b_reg) : (a_reg == b_reg);

    // Every retiring state funnels through one path that launches the next fetch.
    always_comb begin
        retire  = 1'b0;
        next_pc = pc;
        case (state_reg)
            S_MEMWB, S_ALUWB, S_IMMWB: retire = 1'b1;
            S_MEMWR:  retire = mem_ready;
            S_BRANCH: begin
                retire  = 1'b1;
                next_pc = branch_taken ? aluout_reg : pc;
            end
            S_JUMP: begin
                retire  = 1'b1;
                next_pc = {pc[31:28], ir_reg[25:0], 2'b00};
            end
            default: ;
        endcase
    end

    always_comb begin
        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = aluout_reg;
        case (state_reg)
            S_MEMWB: begin
                rf_we = 1'b1;
                rf_wd = mdr_reg;
            end
            S_ALUWB: begin
                rf_we = 1'b1;
                rf_wa = rd;
            end
            S_IMMWB: rf_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_FETCH;
            pc         <= RESET_PC;
            ir_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            aluout_reg <= '0;
            mdr_reg    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            instr_done <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            instr_done <= 1'b0;
            case (state_reg)
                S_FETCH: begin
                    // Only the first fetch after reset arrives here with mem_req low.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ready) begin
                        ir_reg    <= mem_rdata;
                        pc        <= pc + 32'd4;
                        mem_req   <= 1'b0;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_reg      <= rf_rd1;
                    b_reg      <= rf_rd2;
                    aluout_reg <= pc + (imm_sext << 2);
                    state_reg  <= decode_state;
                    if (decode_state == S_TRAP) begin
                        illegal <= 1'b1;
                    end
                end
                S_MEMADR: begin
                    aluout_reg <= a_reg + imm_sext;
                    mem_req    <= 1'b1;
                    mem_addr   <= a_reg + imm_sext;
                    if (opcode == OP_SW) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= b_reg;
                        state_reg <= S_MEMWR;
                    end else begin
                        mem_we    <= 1'b0;
                        state_reg <= S_MEMRD;
                    end
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        mdr_reg   <= mem_rdata;
                        mem_req   <= 1'b0;
                        state_reg <= S_MEMWB;
                    end
                end
                S_EXEC: begin
                    if (funct_ok) begin
                        aluout_reg <= alu(alu_op, a_reg, b_reg);
                        state_reg  <= S_ALUWB;
                    end else begin
                        illegal   <= 1'b1;
                        state_reg <= S_TRAP;
                    end
                end
                S_IMMEX: begin
                    aluout_reg <= imm_result;
                    state_reg  <= S_IMMWB;
                end
                S_TRAP: ;
                default: ;
            endcase

            if (retire) begin
                pc         <= next_pc;
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= next_pc;
                instr_done <= 1'b1;
                state_reg  <= S_FETCH;
            end
        end
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// Self-checking bench for mips_multicycle: unified memory model with wait states,
// table of small programs plus hand-written branch/trap/reset sequences.
module tb_mips_multicycle;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] pc;
    logic        instr_done;
    logic        illegal;

    always #5 clk = ~clk;

    mips_multicycle #(
        .RESET_PC (32'h0000_0000),
        .EXT_OPS  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .pc         (pc),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    // Memory model: 64 words, writes at the completing edge, programmable waits.
    logic [31:0] mem [64];
    logic [31:0] img [64];
    logic        load_req = 1'b0;
    int          wait_cnt = 0;
    int          fetch_waits = 0;
    int          data_waits = 0;
    int          cur_target;

    always_comb begin
        cur_target = (mem_we || mem_addr >= 32'h80) ? data_waits : fetch_waits;
        mem_ready  = mem_req && (wait_cnt >= cur_target);
        mem_rdata  = mem[mem_addr[7:2]];
    end

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= img[i];
        end else if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
        wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 1 : 0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 64; i++) img[i] = (i >= 32) ? (32'hCAFE_0000 | 32'(i)) : 32'h0;
        img[34] = 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        load_req = 1'b1;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        load_req = 1'b0;
    endtask

    // Cycles are counted from the negedge where the first fetch request is seen
    // to the negedge where the n-th retire pulse is seen.
    task automatic run_retires(input string name, input int n, output int cyc,
                               output logic [31:0] first_addr, output logic first_we);
        int started = 0;
        int dones   = 0;
        cyc        = 0;
        first_addr = 32'hFFFF_FFFF;
        first_we   = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (started != 0) cyc++;
            if (started == 0 && mem_req) begin
                started    = 1;
                first_addr = mem_addr;
                first_we   = mem_we;
            end
            if (instr_done) dones++;
            if (dones == n) break;
        end
        if (dones != n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got %0d retires, expected %0d", name, dones, n);
        end
    endtask

    typedef struct packed {
        logic [3:0][31:0] prog;
        int               n;
        int               fw;
        int               dw;
        logic [31:0]      addr;
        logic [31:0]      exp;
        int               cyc;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] p2, input logic [31:0] p3,
                                input int n, input int fw, input int dw,
                                input logic [31:0] addr, input logic [31:0] exp, input int cyc);
        vec_t v;
        v.prog[0] = p0;
        v.prog[1] = p1;
        v.prog[2] = p2;
        v.prog[3] = p3;
        v.n    = n;
        v.fw   = fw;
        v.dw   = dw;
        v.addr = addr;
        v.exp  = exp;
        v.cyc  = cyc;
        return v;
    endfunction

    task automatic branch_seq(input string name, input logic [31:0] i0, input logic [31:0] i1,
                              input logic [31:0] i4, input int n, input logic [31:0] exp_pc,
                              input int exp_cyc);
        int          cyc;
        logic [31:0] fa;
        logic        fwe;
        clear_img();
        img[0] = i0;
        img[1] = i1;
        img[2] = 32'h2000_0000;
        img[3] = 32'h2000_0000;
        img[4] = i4;
        fetch_waits = 0;
        data_waits  = 0;
        do_reset();
        run_retires(name, n, cyc, fa, fwe);
        check({name, " pc"}, pc, exp_pc);
        check({name, " fetch addr"}, mem_req ? mem_addr : 32'hFFFF_FFFF, exp_pc);
        check({name, " cycles"}, 32'(cyc), 32'(exp_cyc));
        $display("%s: pc=%h next fetch=%h cycles=%0d", name, pc, mem_addr, cyc);
    endtask

    vec_t vecs [11];

    initial begin
        int          cyc;
        logic [31:0] fa;
        logic        fwe;
        int          cnt;
        int          bad;
        int          found;

        // addi=0x2002_0005 is addi $2,$0,5; 0x2000_0000 is addi $0,$0,0 (nop)
        vecs[0]  = mk(32'h2002_0005, 32'hAC02_0080, 0, 0, 2, 0, 0, 32'h80, 32'h0000_0005, 8);
        vecs[1]  = mk(32'h8C03_0088, 32'hAC03_0084, 0, 0, 2, 0, 3, 32'h84, 32'hDEAD_BEEF, 15);
        vecs[2]  = mk(32'h2002_0005, 32'h0002_2022, 32'hAC04_0080, 0, 3, 0, 0, 32'h80, 32'hFFFF_FFFB, 12);
        vecs[3]  = mk(32'h2002_0005, 32'h0002_2022, 32'h0082_282A, 32'hAC05_0080, 4, 0, 0, 32'h80, 32'h0000_0001, 16);
        vecs[4]  = mk(32'h2002_0005, 32'h0042_0020, 32'hAC00_0080, 0, 3, 0, 0, 32'h80, 32'h0000_0000, 12);
        vecs[5]  = mk(32'h2006_FFFF, 32'hAC06_0080, 0, 0, 2, 1, 0, 32'h80, 32'hFFFF_FFFF, 10);
        vecs[6]  = mk(32'h3407_8001, 32'hAC07_0080, 0, 0, 2, 0, 0, 32'h80, 32'h0000_8001, 8);
        vecs[7]  = mk(32'h2006_FFFF, 32'h30C8_F0F0, 32'hAC08_0080, 0, 3, 0, 0, 32'h80, 32'h0000_F0F0, 12);
        vecs[8]  = mk(32'h2002_0005, 32'h2003_000C, 32'h0043_4825, 32'hAC09_0080, 4, 0, 0, 32'h80, 32'h0000_000D, 16);
        vecs[9]  = mk(32'h2002_0005, 32'h2003_000C, 32'h0043_4824, 32'hAC09_0080, 4, 1, 2, 32'h80, 32'h0000_0004, 22);
        vecs[10] = mk(32'h2002_008C, 32'h8C43_FFFC, 32'hAC03_0080, 0, 3, 0, 0, 32'h80, 32'hDEAD_BEEF, 13);

        // Reset state, then first fetch and addi timing
        clear_img();
        img[0] = 32'h2002_0005;
        fetch_waits = 0;
        data_waits  = 0;
        reset    = 1'b1;
        load_req = 1'b1;
        repeat (2) @(negedge clk);
        check("reset pc", pc, 32'h0);
        check("reset mem_req", {31'b0, mem_req}, 32'h0);
        check("reset mem_we", {31'b0, mem_we}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset instr_done", {31'b0, instr_done}, 32'h0);
        check("reset illegal", {31'b0, illegal}, 32'h0);
        reset    = 1'b0;
        load_req = 1'b0;
        run_retires("first addi", 1, cyc, fa, fwe);
        check("first req addr", fa, 32'h0);
        check("first req we", {31'b0, fwe}, 32'h0);
        check("first addi cycles", 32'(cyc), 32'd4);
        $display("first addi: first req addr=%h we=%0d cycles=%0d", fa, fwe, cyc);

        // Table of short programs, each ending in a store of the result
        for (int v = 0; v < 11; v++) begin
            clear_img();
            for (int k = 0; k < 4; k++) if (k < vecs[v].n) img[k] = vecs[v].prog[k];
            fetch_waits = vecs[v].fw;
            data_waits  = vecs[v].dw;
            do_reset();
            run_retires($sformatf("vec%0d", v), vecs[v].n, cyc, fa, fwe);
            check($sformatf("vec%0d data", v), mem[vecs[v].addr[7:2]], vecs[v].exp);
            check($sformatf("vec%0d cycles", v), 32'(cyc), 32'(vecs[v].cyc));
            $display("vec%0d: mem[%h]=%h cycles=%0d", v, vecs[v].addr, mem[vecs[v].addr[7:2]], cyc);
        end

        // Store held stable across two wait states
        clear_img();
        img[0] = 32'h2002_0005;
        img[1] = 32'hAC02_0004;
        fetch_waits = 0;
        data_waits  = 2;
        do_reset();
        cnt = 0;
        found = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin
                cnt++;
                check("sw held addr", mem_addr, 32'h4);
                check("sw held wdata", mem_wdata, 32'h5);
            end
            if (instr_done) found++;
            if (found == 2) break;
        end
        check("sw write cycles", 32'(cnt), 32'd3);
        check("sw mem[4]", mem[1], 32'h5);
        $display("sw hold: write req cycles=%0d mem[4]=%h", cnt, mem[1]);

        // Branches and jump
        branch_seq("beq self", 32'h2000_0000, 32'h2000_0000, 32'h1000_FFFF, 5, 32'h10, 19);
        branch_seq("bne equal", 32'h2000_0000, 32'h2000_0000, 32'h1400_FFFF, 5, 32'h14, 19);
        branch_seq("bne taken", 32'h2002_0005, 32'h1440_0001, 32'h2000_0000, 2, 32'h0C, 7);
        branch_seq("jump", 32'h0800_0008, 32'h2000_0000, 32'h2000_0000, 1, 32'h20, 3);

        // Illegal opcode halts the core with no further requests
        clear_img();
        img[0] = 32'hFC00_0000;
        fetch_waits = 0;
        data_waits  = 0;
        do_reset();
        bad = 0;
        cnt = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (illegal && mem_req) bad++;
            if (instr_done) cnt++;
        end
        check("trap illegal", {31'b0, illegal}, 32'h1);
        check("trap req after", 32'(bad), 32'h0);
        check("trap retires", 32'(cnt), 32'h0);
        check("trap pc", pc, 32'h4);
        $display("trap opcode: illegal=%0d pc=%h", illegal, pc);

        // Unknown R-type funct traps too
        clear_img();
        do_reset();
        repeat (20) @(negedge clk);
        check("trap funct", {31'b0, illegal}, 32'h1);
        $display("trap funct: illegal=%0d", illegal);

        // Reset while a load is stalled
        clear_img();
        img[0] = 32'h8C03_0088;
        data_waits = 50;
        do_reset();
        found = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 32'h88) begin
                found = 1;
                break;
            end
        end
        check("memrd reached", 32'(found), 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset drops req", {31'b0, mem_req}, 32'h0);
        check("reset pc reload", pc, 32'h0);
        reset = 1'b0;
        data_waits = 0;
        $display("reset in memrd: mem_req=%0d pc=%h", mem_req, pc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
